sd_spi_master: RTL and testbench
================================

Name: sd_spi_master

Overview:
- Byte-oriented SPI mode-0 initiator that drives the SD card interface (sd_cs, spi_clk, spi_mosi, spi_miso) from the system side.
- It is the opposite end of the sd_card_emu responder used in simulation. The 6502 register front-end pushes one byte and receives one byte per transfer through valid/ready handshakes.
- The SPI clock rate is programmable, so card init can run at ≤400 kHz and data transfers can run fast.

Parameters:
- DIV_WIDTH, 8: width of the clock-divider input.
- IDLE_MOSI, 1'b1: level driven on spi_mosi when no byte is shifting. SD requires 0xFF fill.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_div  input  DIV_WIDTH  half-period of spi_clk in clk cycles, minus 1.
- i_cs_assert  input  1  1 = card selected (sd_cs low).
- i_tx_valid  input  1  byte offered.
- i_tx_data  input  8  byte to send, MSB first.
- o_tx_ready  output  1  master can accept a byte.
- o_rx_valid  output  1  one-cycle pulse, received byte valid.
- o_rx_data  output  8  received byte; held until the next o_rx_valid.
- o_busy  output  1  byte in flight.
- sd_cs  output  1  active-low chip select.
- spi_clk  output  1  SPI clock, CPOL=0.
- spi_mosi  output  1  serial out.
- spi_miso  input  1  serial in; synchronised internally is NOT done.

Behaviour:
- Reset values (async on rst_n low):
  - o_tx_ready=1, o_rx_valid=0, o_rx_data=0x00, o_busy=0.
  - sd_cs=1, spi_clk=0, spi_mosi=IDLE_MOSI.
  - State=IDLE, divider count=0, bit count=0.
- States:
  - IDLE: o_tx_ready=1.
  - SHIFT: o_busy=1, o_tx_ready=0.
- IDLE→SHIFT on an accept (i_tx_valid && o_tx_ready) at edge E0. At that edge:
  - Latch i_tx_data into the TX shift register and i_div into div_q.
  - spi_mosi ← i_tx_data[7]; spi_clk stays 0; counters clear.
- Divider:
  - The count runs 0..div_q. At terminal count spi_clk toggles and the count wraps to 0.
  - i_div changes mid-byte are ignored; div_q is sampled only at accept.
- Edges:
  - Rising spi_clk edge: shift spi_miso into the RX shift register LSB.
  - Falling spi_clk edge: present the next TX bit on spi_mosi.
  - There are 8 rising and 8 falling edges per byte.
- Edge timing:
  - The first spi_clk rise is at E0+(div_q+1).
  - The final (8th) fall is at E0+16·(div_q+1).
- At the final fall (SHIFT→IDLE):
  - o_rx_data ← assembled byte and o_rx_valid=1 for exactly one cycle.
  - o_tx_ready=1, o_busy=0, spi_mosi ← IDLE_MOSI, spi_clk=0.
  - No extra bit is shifted out.
- Back-to-back transfers: the earliest next accept is the edge after o_rx_valid rises, so the byte period is 16·(div_q+1)+1 clk cycles.
- RX has no backpressure. Consumers must take o_rx_data on the o_rx_valid pulse; the value persists until overwritten.
- Chip select:
  - sd_cs ← ~i_cs_assert, registered one cycle, only while in IDLE.
  - An i_cs_assert change during SHIFT is applied on the first IDLE cycle after the byte completes, so CS never toggles mid-byte.
  - A simultaneous accept and CS change in IDLE: the CS change takes effect at the same edge as the accept.
- Transfers while sd_cs=1 are legal; they produce clock-only dummy bytes, as needed for the SD 74-clock init.
- Reset mid-byte: immediate return to reset values. No o_rx_valid pulse; the partial byte is discarded.
- Minimum i_div=0 gives spi_clk = clk/2.

Decomposition:
- sd_spi_pkg holds:
  - typedef enum {IDLE, SHIFT} spi_state_t;
  - localparam BITS_PER_BYTE=8.
- Natural sub-module: sd_spi_clkgen. It holds the divider counter, issues a terminal-count strobe, and produces spi_clk with rise_en/fall_en pulses. It is reset by rst_n, cleared on accept, and enabled only in SHIFT.

Test Plan:
- Loopback (spi_mosi→spi_miso), i_div=0, send 0xA5:
  - spi_clk period 2 clk.
  - o_rx_valid exactly 16 cycles after the accept edge; o_rx_data=0xA5.
  - 8 rising spi_clk edges counted.
- i_div=3, sd_card_emu idle returning 0xFF, send 0xFF:
  - spi_clk high/low 4 clk each; o_rx_data=0xFF at 64 cycles.
  - MOSI high throughout.
- Back-to-back, i_tx_valid held with 0x40 then 0x00, i_div=1:
  - Two o_rx_valid pulses 33 cycles apart.
  - spi_clk low for exactly 1 extra cycle between bytes.
- Drop i_cs_assert at bit 3 of a byte:
  - sd_cs stays 0 until that byte's o_rx_valid, then goes 1 one cycle later.
  - No spi_clk edges after sd_cs=1.
- Assert rst_n low after 4 rising edges of byte 0x3C:
  - All outputs at reset values within the same cycle; no o_rx_valid.
  - A new send of 0x81 after release returns 0x81 on loopback.
- i_div changed from 0 to 7 mid-byte: the current byte completes at 16 cycles; the next accepted byte takes 128 cycles.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI initiator.
package sd_spi_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_t;

    localparam int unsigned BITS_PER_BYTE = 8;
    localparam int unsigned BIT_CNT_W     = $clog2(BITS_PER_BYTE);

endpackage

// File: rtl/sd_spi_clkgen.sv
// SPI clock generator: programmable half-period divider producing a CPOL=0
// spi_clk plus strobes marking the clk edge at which spi_clk rises or falls.
module sd_spi_clkgen #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear_i,
    input  logic                 en_i,
    input  logic [DIV_WIDTH-1:0] div_i,
    output logic                 spi_clk_o,
    output logic                 rise_en_o,
    output logic                 fall_en_o
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 spi_clk_q;
    logic                 tick;

    // Terminal count; the strobes fire on the same clk edge that toggles spi_clk.
    assign tick      = en_i && (cnt_q == div_q);
    assign rise_en_o = tick && !spi_clk_q;
    assign fall_en_o = tick && spi_clk_q;
    assign spi_clk_o = spi_clk_q;

    // Divider count and spi_clk; the divisor is captured only when a byte is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            cnt_q     <= '0;
            spi_clk_q <= 1'b0;
        end else if (clear_i) begin
            div_q     <= div_i;
            cnt_q     <= '0;
            spi_clk_q <= 1'b0;
        end else if (en_i) begin
            if (tick) begin
                cnt_q     <= '0;
                spi_clk_q <= ~spi_clk_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sd_spi_master.sv
// Byte-oriented SPI mode-0 initiator for an SD card: one byte out, one byte in
// per transfer, with valid/ready on the TX side and a one-cycle RX pulse.
module sd_spi_master
    import sd_spi_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 8,
    parameter logic        IDLE_MOSI = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DIV_WIDTH-1:0] i_div,
    input  logic                 i_cs_assert,
    input  logic                 i_tx_valid,
    input  logic [7:0]           i_tx_data,
    output logic                 o_tx_ready,
    output logic                 o_rx_valid,
    output logic [7:0]           o_rx_data,
    output logic                 o_busy,
    output logic                 sd_cs,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    spi_state_t           state_q;
    logic                 tx_ready_q;
    logic                 busy_q;
    logic                 rx_valid_q;
    logic [7:0]           rx_data_q;
    logic                 cs_q;
    logic                 mosi_q;
    logic [7:0]           tx_sr_q;
    logic [7:0]           rx_sr_q;
    logic [BIT_CNT_W-1:0] bit_cnt_q;

    logic accept;
    logic rise_en;
    logic fall_en;

    assign accept = i_tx_valid && tx_ready_q;

    sd_spi_clkgen #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_clkgen (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (accept),
        .en_i      (state_q == SHIFT),
        .div_i     (i_div),
        .spi_clk_o (spi_clk),
        .rise_en_o (rise_en),
        .fall_en_o (fall_en)
    );

    assign o_tx_ready = tx_ready_q;
    assign o_busy     = busy_q;
    assign o_rx_valid = rx_valid_q;
    assign o_rx_data  = rx_data_q;
    assign sd_cs      = cs_q;
    assign spi_mosi   = mosi_q;

    // Transfer FSM with registered outputs; CS only follows the request while idle
    // so it can never change in the middle of a byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            cs_q       <= 1'b1;
            mosi_q     <= IDLE_MOSI;
            tx_sr_q    <= 8'h00;
            rx_sr_q    <= 8'h00;
            bit_cnt_q  <= '0;
        end else begin
            rx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    cs_q <= ~i_cs_assert;
                    if (accept) begin
                        state_q    <= SHIFT;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        tx_sr_q    <= i_tx_data;
                        mosi_q     <= i_tx_data[7];
                        rx_sr_q    <= 8'h00;
                        bit_cnt_q  <= '0;
                    end
                end
                SHIFT: begin
                    if (rise_en) begin
                        rx_sr_q <= {rx_sr_q[6:0], spi_miso};
                    end
                    if (fall_en) begin
                        if (bit_cnt_q == BIT_CNT_W'(BITS_PER_BYTE - 1)) begin
                            // Last fall: all 8 bits already sampled, nothing more to drive.
                            state_q    <= IDLE;
                            tx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= rx_sr_q;
                            mosi_q     <= IDLE_MOSI;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_sr_q   <= {tx_sr_q[6:0], 1'b0};
                            mosi_q    <= tx_sr_q[6];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_master.sv
// Directed testbench for sd_spi_master: loopback, card-idle, back-to-back,
// CS release, mid-byte reset and divider-change scenarios.
module tb_sd_spi_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] i_div;
    logic       i_cs_assert;
    logic       i_tx_valid;
    logic [7:0] i_tx_data;
    logic       o_tx_ready;
    logic       o_rx_valid;
    logic [7:0] o_rx_data;
    logic       o_busy;
    logic       sd_cs;
    logic       spi_clk;
    logic       spi_mosi;
    logic       spi_miso;

    logic       loop_en;
    logic       miso_val;

    assign spi_miso = loop_en ? spi_mosi : miso_val;

    sd_spi_master dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_div       (i_div),
        .i_cs_assert (i_cs_assert),
        .i_tx_valid  (i_tx_valid),
        .i_tx_data   (i_tx_data),
        .o_tx_ready  (o_tx_ready),
        .o_rx_valid  (o_rx_valid),
        .o_rx_data   (o_rx_data),
        .o_busy      (o_busy),
        .sd_cs       (sd_cs),
        .spi_clk     (spi_clk),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Activity trackers, updated once per clk cycle by step()
    int   cyc;
    int   rises;
    int   falls;
    int   first_rise;
    int   last_rise;
    int   next_rise;
    int   hi_run;
    int   hi_max;
    int   mosi_low;
    int   edge_cs_hi;
    logic prev_sclk = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc = cyc + 1;
        if (spi_clk && !prev_sclk) begin
            rises = rises + 1;
            if (rises == 1) first_rise = cyc;
            last_rise = cyc;
            if (next_rise == 0) next_rise = cyc;
            hi_run = 1;
        end else if (spi_clk) begin
            hi_run = hi_run + 1;
        end
        if (!spi_clk && prev_sclk) begin
            falls = falls + 1;
            if (hi_run > hi_max) hi_max = hi_run;
        end
        if ((spi_clk !== prev_sclk) && sd_cs) edge_cs_hi = edge_cs_hi + 1;
        if (o_busy && !spi_mosi) mosi_low = mosi_low + 1;
        prev_sclk = spi_clk;
    endtask

    task automatic clear_trackers();
        cyc        = 0;
        rises      = 0;
        falls      = 0;
        first_rise = 0;
        last_rise  = 0;
        next_rise  = 1;
        hi_run     = 0;
        hi_max     = 0;
        mosi_low   = 0;
        edge_cs_hi = 0;
    endtask

    // Offer one byte; returns with the accept edge E0 just past and cyc = 0.
    task automatic send_start(input logic [7:0] data, input logic [7:0] div);
        i_tx_data  = data;
        i_div      = div;
        i_tx_valid = 1'b1;
        step();
        i_tx_valid = 1'b0;
        clear_trackers();
    endtask

    // Bounded wait for o_rx_valid; lat = cyc at the pulse, or -1 on timeout.
    task automatic wait_rx(input int maxc, output int lat);
        lat = -1;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (o_rx_valid) begin
                lat = cyc;
                break;
            end
        end
    endtask

    int         lat;
    int         lat2;
    int         cnt;
    logic [7:0] rxd;

    initial begin
        rst_n       = 1'b0;
        i_div       = 8'd0;
        i_cs_assert = 1'b0;
        i_tx_valid  = 1'b0;
        i_tx_data   = 8'h00;
        loop_en     = 1'b1;
        miso_val    = 1'b1;
        clear_trackers();

        // Reset values
        step();
        step();
        chk("rst_tx_ready", 32'(o_tx_ready), 32'd1);
        chk("rst_rx_valid", 32'(o_rx_valid), 32'd0);
        chk("rst_rx_data", 32'(o_rx_data), 32'h00);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_sd_cs", 32'(sd_cs), 32'd1);
        chk("rst_spi_clk", 32'(spi_clk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd1);
        rst_n = 1'b1;
        step();

        // Loopback, div 0, 0xA5
        i_cs_assert = 1'b1;
        send_start(8'hA5, 8'd0);
        chk("t1_busy", 32'(o_busy), 32'd1);
        chk("t1_cs_low", 32'(sd_cs), 32'd0);
        wait_rx(100, lat);
        chk("t1_latency", 32'(lat), 32'd16);
        chk("t1_rx_data", 32'(o_rx_data), 32'hA5);
        chk("t1_rises", 32'(rises), 32'd8);
        chk("t1_falls", 32'(falls), 32'd8);
        chk("t1_first_rise", 32'(first_rise), 32'd1);
        chk("t1_last_rise", 32'(last_rise), 32'd15);
        chk("t1_hi_len", 32'(hi_max), 32'd1);
        step();
        chk("t1_rx_pulse_1cyc", 32'(o_rx_valid), 32'd0);
        chk("t1_ready_after", 32'(o_tx_ready), 32'd1);
        chk("t1_busy_after", 32'(o_busy), 32'd0);
        chk("t1_rx_held", 32'(o_rx_data), 32'hA5);

        // Card idle returning 0xFF, div 3
        loop_en  = 1'b0;
        miso_val = 1'b1;
        send_start(8'hFF, 8'd3);
        wait_rx(200, lat);
        chk("t2_latency", 32'(lat), 32'd64);
        chk("t2_rx_data", 32'(o_rx_data), 32'hFF);
        chk("t2_first_rise", 32'(first_rise), 32'd4);
        chk("t2_last_rise", 32'(last_rise), 32'd60);
        chk("t2_hi_len", 32'(hi_max), 32'd4);
        chk("t2_mosi_low", 32'(mosi_low), 32'd0);
        loop_en = 1'b1;
        step();

        // Back-to-back with i_tx_valid held, div 1
        i_tx_data  = 8'h40;
        i_div      = 8'd1;
        i_tx_valid = 1'b1;
        step();
        clear_trackers();
        i_tx_data = 8'h00;
        wait_rx(200, lat);
        rxd = o_rx_data;
        chk("t3_lat1", 32'(lat), 32'd32);
        chk("t3_rx1", 32'(rxd), 32'h40);
        chk("t3_ready_at_pulse", 32'(o_tx_ready), 32'd1);
        next_rise = 0;
        step();
        i_tx_valid = 1'b0;
        chk("t3_reaccept_busy", 32'(o_busy), 32'd1);
        wait_rx(200, lat2);
        chk("t3_gap", 32'(lat2 - lat), 32'd33);
        chk("t3_rx2", 32'(o_rx_data), 32'h00);
        chk("t3_low_gap", 32'(next_rise - lat), 32'd3);
        chk("t3_rises", 32'(rises), 32'd16);
        chk("t3_mosi_idle", 32'(spi_mosi), 32'd1);
        step();

        // CS dropped at bit 3 of a byte, div 1
        i_cs_assert = 1'b1;
        send_start(8'h5A, 8'd1);
        for (int i = 0; i < 100; i++) begin
            if (rises >= 3) break;
            step();
        end
        chk("t4_rises_at_drop", 32'(rises), 32'd3);
        i_cs_assert = 1'b0;
        cnt = 0;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (sd_cs) cnt = cnt + 1;
            if (o_rx_valid) begin
                lat = cyc;
                break;
            end
        end
        chk("t4_latency", 32'(lat), 32'd32);
        chk("t4_cs_held_low", 32'(cnt), 32'd0);
        chk("t4_rx_data", 32'(o_rx_data), 32'h5A);
        step();
        chk("t4_cs_released", 32'(sd_cs), 32'd1);
        edge_cs_hi = 0;
        for (int i = 0; i < 10; i++) step();
        chk("t4_no_edges_cs_hi", 32'(edge_cs_hi), 32'd0);

        // Reset after 4 rising edges of 0x3C
        i_cs_assert = 1'b1;
        send_start(8'h3C, 8'd1);
        for (int i = 0; i < 100; i++) begin
            if (rises >= 4) break;
            step();
        end
        chk("t5_rises_before_rst", 32'(rises), 32'd4);
        rst_n = 1'b0;
        #1;
        chk("t5_busy", 32'(o_busy), 32'd0);
        chk("t5_tx_ready", 32'(o_tx_ready), 32'd1);
        chk("t5_sd_cs", 32'(sd_cs), 32'd1);
        chk("t5_spi_clk", 32'(spi_clk), 32'd0);
        chk("t5_mosi", 32'(spi_mosi), 32'd1);
        chk("t5_rx_data", 32'(o_rx_data), 32'h00);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (o_rx_valid) cnt = cnt + 1;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (o_rx_valid) cnt = cnt + 1;
        end
        chk("t5_no_rx_valid", 32'(cnt), 32'd0);
        send_start(8'h81, 8'd1);
        wait_rx(200, lat);
        chk("t5_latency", 32'(lat), 32'd32);
        chk("t5_rx_data_after", 32'(o_rx_data), 32'h81);
        step();

        // Divider change mid-byte only affects the next byte
        send_start(8'h33, 8'd0);
        step();
        step();
        step();
        i_div = 8'd7;
        wait_rx(100, lat);
        chk("t6_lat_div0", 32'(lat), 32'd16);
        chk("t6_rx1", 32'(o_rx_data), 32'h33);
        send_start(8'hC3, 8'd7);
        wait_rx(300, lat);
        chk("t6_lat_div7", 32'(lat), 32'd128);
        chk("t6_rx2", 32'(o_rx_data), 32'hC3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
